// File: rtl/rv_pkg.sv
// Shared definitions for the rv_* instruction fetch slice: widths, reset PC,
// major opcodes and the buffered instruction/PC record.
package rv_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct packed {
    logic [31:0]         inst;
    logic [XLEN_DEF-1:0] pc;
  } inst_pc_t;

endpackage

// File: rtl/rv_fetch_unit_fifo.sv
// Synchronous FIFO with flush and occupancy count; the head entry is read
// combinationally from storage so data is visible the cycle after the push.
module rv_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, instruction buffer, redirect flush.
// Optional build macro FETCH_MISALIGN_CHECK_EN: misaligned redirect sets sticky fetch_fault and halts fetch.
module rv_fetch_unit
  import rv_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_inst,
  output logic [XLEN-1:0] dec_pc,
  output logic [6:0]      dec_opcode,
  output logic            fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0]    r_pc;
  logic [CW-1:0]      r_drop;
  logic               w_halt;
  logic               w_req_fire;
  logic               w_rsp_keep;
  logic               w_dec_fire;
  logic [CW:0]        w_credit_used;
  logic [XLEN-1:0]    w_target_pc;
  logic [XLEN-1:0]    w_rsp_pc;
  logic               w_tag_empty;
  logic               w_tag_full;
  logic [CW-1:0]      w_tag_count;
  logic [32+XLEN-1:0] w_buf_head;
  logic               w_buf_empty;
  logic               w_buf_full;
  logic [CW-1:0]      w_buf_count;

  assign w_target_pc   = {redirect_pc[XLEN-1:2], 2'b00};
  // Outstanding requests plus buffered words never exceed the buffer size.
  assign w_credit_used = {1'b0, w_tag_count} + {1'b0, w_buf_count};

  assign imem_req_valid = !rst && !redirect_valid && !w_halt &&
                          (w_credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_rsp_keep     = imem_rsp_valid && !redirect_valid && (r_drop == '0);

  assign dec_valid  = !w_buf_empty;
  assign w_dec_fire = dec_valid && dec_ready;
  assign dec_inst   = dec_valid ? w_buf_head[32+XLEN-1:XLEN] : '0;
  assign dec_pc     = dec_valid ? w_buf_head[XLEN-1:0] : '0;
  assign dec_opcode = dec_inst[6:0];

  // Tag FIFO occupancy doubles as the outstanding-request count; it is never
  // flushed so responses destined to be dropped still retire their tags.
  rv_sync_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (1'b0),
    .i_push  (w_req_fire),
    .i_wdata (r_pc),
    .i_pop   (imem_rsp_valid),
    .o_rdata (w_rsp_pc),
    .o_empty (w_tag_empty),
    .o_full  (w_tag_full),
    .o_count (w_tag_count)
  );

  rv_sync_fifo #(.WIDTH(32+XLEN), .DEPTH(FIFO_DEPTH)) u_inst_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_rsp_keep),
    .i_wdata ({imem_rsp_data, w_rsp_pc}),
    .i_pop   (w_dec_fire),
    .o_rdata (w_buf_head),
    .o_empty (w_buf_empty),
    .o_full  (w_buf_full),
    .o_count (w_buf_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_drop <= '0;
    end else if (redirect_valid) begin
      r_pc   <= w_target_pc;
      r_drop <= w_tag_count - CW'(imem_rsp_valid);
    end else begin
      if (w_req_fire) r_pc <= r_pc + XLEN'(4);
      if (imem_rsp_valid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      r_fault <= 1'b1;
    end
  end

  assign w_halt      = r_fault;
  assign fetch_fault = r_fault;
`else
  logic w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^redirect_pc[1:0];
  assign w_halt          = 1'b0;
  assign fetch_fault     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && w_tag_empty));
      assert (!(w_req_fire && w_tag_full));
      assert (!(w_rsp_keep && w_buf_full));
    end
  end

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Scoreboard bench for rv_fetch_unit: a behavioural instruction memory with
// programmable latency/readiness, and a monitor checking every decode handshake.
module tb_rv_fetch_unit;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [6:0]  dec_opcode;
  logic        fetch_fault;

  rv_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .dec_opcode     (dec_opcode),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] op;
    if (a == 32'h0) return 32'h00A00093;
    case (a[3:2])
      2'd0:    op = OP_R;
      2'd1:    op = OP_IMM;
      2'd2:    op = OP_LOAD;
      default: op = OP_STORE;
    endcase
    return {a[26:2] ^ 25'h15A5A5A, op};
  endfunction

  // Memory model: accepted requests return in order after mem_lat cycles.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  int    mem_lat  = 1;
  bit    rdy_rand = 1'b0;
  int    n_acc    = 0;

  always @(negedge clk) begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
    imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #2;
    if (!rst && imem_req_valid && imem_req_ready) begin
      mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
      n_acc++;
    end
  end

  // Scoreboard of expected decode PCs; decode only accepts while one is expected.
  logic [31:0] sbq[$];

  always @(negedge clk) begin
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    dec_ready = (sbq.size() > 0);
    #2;
    if (!rst) begin
      if (dec_valid && dec_ready) begin
        exp_pc   = sbq.pop_front();
        exp_inst = mem_word(exp_pc);
        chk("dec_pc", dec_pc, exp_pc);
        chk("dec_inst", dec_inst, exp_inst);
        chk("dec_opcode", {25'd0, dec_opcode}, {25'd0, exp_inst[6:0]});
      end else if (!dec_valid) begin
        chk("idle_zero", dec_inst | dec_pc | {25'd0, dec_opcode}, 32'h0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) sbq.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_empty(input string name, input int budget);
    int t = 0;
    while (sbq.size() > 0 && t < budget) begin
      tick();
      t++;
    end
    chk(name, 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  acc0;
    int  t;
    bit  found;

    // Reset state
    repeat (2) tick();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
    rst = 1'b0;

    // Sequential stream, 1-cycle memory
    push_run(32'h0, 20);
    wait_empty("seq_drain", 300);

    // Decode stall: buffer holds exactly two words, requests stop
    repeat (10) tick();
    chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("stall_dec_valid", {31'd0, dec_valid}, 32'd1);
    chk("stall_head_pc", dec_pc, 32'd80);
    chk("stall_accepts", 32'(n_acc), 32'd22);

    // Random ready, 3-cycle latency
    rdy_rand = 1'b1;
    mem_lat  = 3;
    push_run(32'd80, 30);
    wait_empty("rand_drain", 1500);
    rdy_rand = 1'b0;
    repeat (12) tick();
    chk("rand_accepts", 32'(n_acc), 32'd52);
    chk("rand_head_pc", dec_pc, 32'd200);

    // Redirect with two requests in flight
    push_run(32'd200, 2);
    found = 1'b0;
    t = 0;
    while (!found && t < 100) begin
      tick();
      t++;
      found = (mq.size() == 2) && !imem_rsp_valid && (sbq.size() == 0);
    end
    chk("two_outstanding_seen", {31'd0, found}, 32'd1);
    push_run(32'h100, 4);
    redirect(32'h100);
    wait_empty("redir_drain", 300);

    // Redirect coinciding with a response and a decode pop
    mem_lat = 1;
    repeat (8) tick();
    push_run(32'h110, 8);
    found = 1'b0;
    t = 0;
    while (!found && t < 60) begin
      tick();
      t++;
      found = imem_rsp_valid && dec_valid && dec_ready;
    end
    chk("coincide_seen", {31'd0, found}, 32'd1);
    if (found) begin
      while (sbq.size() > 1) void'(sbq.pop_back());
      push_run(32'h200, 3);
      redirect(32'h200);
      chk("flush_dec_valid", {31'd0, dec_valid}, 32'd0);
    end
    wait_empty("coincide_drain", 300);

    // PC wraps past the top of the address space
    repeat (8) tick();
    push_run(32'hFFFF_FFF8, 4);
    redirect(32'hFFFF_FFF8);
    wait_empty("wrap_drain", 300);

    // Misaligned redirect
    repeat (8) tick();
    acc0 = n_acc;
`ifdef FETCH_MISALIGN_CHECK_EN
    redirect(32'h102);
    repeat (10) tick();
    chk("fault_set", {31'd0, fetch_fault}, 32'd1);
    chk("fault_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("fault_accepts", 32'(n_acc), 32'(acc0));
    chk("fault_dec_valid", {31'd0, dec_valid}, 32'd0);
    repeat (5) tick();
    chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
`else
    push_run(32'h100, 2);
    redirect(32'h102);
    wait_empty("misalign_drain", 300);
    chk("no_fault", {31'd0, fetch_fault}, 32'd0);
    chk("misalign_accepts_grew", {31'd0, n_acc > acc0}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_fetch_unit.md
Name: rv_fetch_unit

Overview:
Instruction fetch stage. Sits directly upstream of the control decoder and supplies instruction words to it.
- Holds the PC and issues word reads to instruction memory over a valid/ready request with in-order responses.
- Buffers returned words in a small FIFO and presents instruction, PC and the opcode field to decode with a valid/ready handshake.
- A redirect input (branch/jump target) flushes the FIFO and any in-flight words.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  response word valid; responses return in request order, never back-pressured
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  redirect strobe from execute
redirect_pc  in  XLEN  redirect target
dec_valid  out  1  instruction available to decode
dec_ready  in  1  decode consumes instruction
dec_inst  out  32  instruction word
dec_pc  out  XLEN  PC of dec_inst
dec_opcode  out  7  dec_inst[6:0], feeds the control decoder opcode input
fetch_fault  out  1  misaligned-redirect fault (optional feature only, else tied 0)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values:
  - pc = RESET_PC; FIFO empty; outstanding = 0; drop = 0.
  - imem_req_valid = 0, dec_valid = 0, fetch_fault = 0.
  - dec_inst, dec_pc and dec_opcode are 0 while dec_valid = 0.
- Request issue:
  - imem_req_valid = 1 when (outstanding + fifo_count) < FIFO_DEPTH and no redirect is pending this cycle.
  - imem_req_addr = pc.
  - On req_valid & req_ready: pc <= pc + 4 (mod 2^XLEN, wraps silently); outstanding++.
- Response:
  - On imem_rsp_valid: outstanding--.
  - If drop > 0: discard the word and drop--.
  - Otherwise push {data, pc_tag} into the FIFO. pc_tag comes from a tag FIFO written at request acceptance.
  - Credit counting guarantees the FIFO never overflows. A response arriving while the FIFO is full is an assertion error.
- Decode side:
  - dec_valid = FIFO non-empty; head entry drives dec_inst, dec_pc and dec_opcode.
  - dec_valid & dec_ready pops the head.
  - Push and pop in the same cycle leave the count unchanged.
  - Minimum latency: request accepted in cycle N, response in N+k, dec_valid in N+k+1 (registered FIFO).
- Redirect (priority over all else in that cycle):
  - pc <= redirect_pc; FIFO flushed (count = 0, dec_valid drops next cycle).
  - drop <= outstanding minus any response arriving in the same cycle.
  - No request is issued in the redirect cycle.
  - A pop in the redirect cycle is still accepted by decode; the flush wins for the next state.
- Simultaneous response and redirect: the arriving word is discarded.
- rst asserted mid-operation: full reset next edge; in-flight responses arriving after reset are the memory's responsibility (the memory is reset by the same rst).

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined: redirect_pc[1:0] != 0 sets fetch_fault (sticky until rst); pc is still loaded with redirect_pc & ~3; the flush proceeds; fetching halts (imem_req_valid = 0) while fetch_fault = 1.
- Undefined: low two bits are ignored (pc = redirect_pc & ~3), fetch_fault is tied 0 and fetching never halts.

Decomposition:
- Shared package rv_pkg:
  - XLEN default, RESET_PC default.
  - Opcode localparams (OP_R 7'b0110011, OP_IMM 7'b0010011, OP_LOAD 7'b0000011, OP_STORE 7'b0100011).
  - inst_pc_t struct {inst, pc}.
- One natural sub-module: rv_sync_fifo (parameterised width/depth, flush input, count output), instantiated for the instruction buffer. The tag FIFO is either a second instance or merged into the outstanding tracking.

Test Plan:
- Reset, memory always ready with 1-cycle response, dec_ready=1 -> addresses 0,4,8,... and dec_pc 0,4,8; dec_opcode equals inst[6:0] (e.g. 32'h00A00093 -> 7'b0010011).
- dec_ready=0 for 10 cycles -> exactly FIFO_DEPTH words buffered, imem_req_valid=0, no overflow; on release, words pop in order with no loss.
- imem_req_ready toggled randomly and 3-cycle response latency -> in-order stream, no duplicate or skipped PC.
- Redirect to 32'h100 with 2 requests outstanding -> both late responses dropped; next dec_pc = 32'h100, then 32'h104.
- Redirect in the same cycle as rsp_valid and dec_ready pop -> response discarded; dec_valid=0 next cycle; fetch resumes at target.
- With FETCH_MISALIGN_CHECK_EN, redirect to 32'h102 -> fetch_fault=1 and stays 1, no further requests; without the macro, fetch continues at 32'h100.
